// File: rtl/fifo_readout_ctrl.sv
// rtl/fifo_readout_ctrl.sv - frame readout from a 32x8192 FIFO into a header-prefixed output stream
module fifo_readout_ctrl #(
  parameter int          RD_LATENCY  = 1,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [31:0] PAD_WORD    = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [13:0] BURST_LEN,
  input  logic        CLR_FLAGS,
  input  logic        FIFO_EMPTY,
  input  logic [31:0] FIFO_Q,
  output logic        FIFO_RE,
  output logic [31:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        OUT_LAST,
  output logic        BUSY,
  output logic        DONE,
  output logic        CFG_ERR,
  output logic        TIMEOUT_FLAG
);

  localparam int EW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_READ, S_PAD, S_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [13:0]           burst_q, burst_d;
  logic [13:0]           req_cnt_q, req_cnt_d;
  logic [13:0]           dat_cnt_q, dat_cnt_d;
  logic [EW-1:0]         empty_cnt_q, empty_cnt_d;
  logic                  timed_out_q, timed_out_d;
  logic [RD_LATENCY-1:0] re_pipe_q, re_pipe_d;
  logic [32:0]           buf_q [4];
  logic [32:0]           buf_d [4];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            count_q, count_d;
  logic [9:0]            frame_cnt_q, frame_cnt_d;
  logic                  done_q, done_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  timeout_flag_q, timeout_flag_d;

  logic        fifo_re;
  logic [2:0]  inflight;
  logic        pop;
  logic        out_last;
  logic        push;
  logic        push_data;
  logic [32:0] push_word;
  logic        set_cfg;
  logic        set_to;

  // Read enable: only issue a read when every outstanding word already has a buffer slot reserved
  always_comb begin
    inflight = 3'd0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + {2'b00, re_pipe_q[i]};
    end
    fifo_re = (state_q == S_READ) && !timed_out_q && !FIFO_EMPTY && (req_cnt_q < burst_q) &&
              (({1'b0, count_q} + {1'b0, inflight}) < 4'd4);
  end

  assign pop      = (count_q != 3'd0) && OUT_READY;
  assign out_last = (count_q != 3'd0) && buf_q[rd_ptr_q][32];

  // Next-state logic for the frame sequencer, read pipeline, output buffer and flags
  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    req_cnt_d    = req_cnt_q;
    dat_cnt_d    = dat_cnt_q;
    empty_cnt_d  = empty_cnt_q;
    timed_out_d  = timed_out_q;
    re_pipe_d    = re_pipe_q << 1;
    re_pipe_d[0] = fifo_re;
    buf_d        = buf_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    frame_cnt_d  = frame_cnt_q;
    done_d       = 1'b0;
    set_cfg      = 1'b0;
    set_to       = 1'b0;
    push         = 1'b0;
    push_data    = 1'b0;
    push_word    = 33'd0;

    // Starvation watchdog; only counts while waiting on data in READ
    if (!FIFO_EMPTY) begin
      empty_cnt_d = '0;
    end else if (state_q == S_READ && !timed_out_q) begin
      empty_cnt_d = empty_cnt_q + 1'b1;
      if (empty_cnt_q == EW'(TIMEOUT_CYC - 1)) begin
        timed_out_d = 1'b1;
        set_to      = 1'b1;
      end
    end

    // A word lands RD_LATENCY cycles after its read; its slot was reserved at issue
    if (re_pipe_q[RD_LATENCY-1]) begin
      push      = 1'b1;
      push_data = 1'b1;
      push_word = {(dat_cnt_q + 14'd1 == burst_q), FIFO_Q};
    end

    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (BURST_LEN != 14'd0 && BURST_LEN <= 14'd8192) begin
            burst_d     = BURST_LEN;
            req_cnt_d   = 14'd0;
            dat_cnt_d   = 14'd0;
            empty_cnt_d = '0;
            timed_out_d = 1'b0;
            state_d     = S_HEADER;
          end else begin
            set_cfg = 1'b1;
          end
        end
      end
      S_HEADER: begin
        if (count_q < 3'd4) begin
          push      = 1'b1;
          push_word = {1'b0, 8'hA5, frame_cnt_q, burst_q};
          state_d   = S_READ;
        end
      end
      S_READ: begin
        if (fifo_re) begin
          req_cnt_d = req_cnt_q + 14'd1;
          if (req_cnt_q + 14'd1 == burst_q) begin
            state_d = S_FLUSH;
          end
        end else if (timed_out_q && inflight == 3'd0) begin
          state_d = S_PAD;
        end
      end
      S_PAD: begin
        if (count_q < 3'd4) begin
          push      = 1'b1;
          push_data = 1'b1;
          push_word = {(dat_cnt_q + 14'd1 == burst_q), PAD_WORD};
          if (dat_cnt_q + 14'd1 == burst_q) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // The LAST word is always the final buffer entry, so its transfer empties the buffer
        if (pop && out_last) begin
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 10'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push_data) begin
      dat_cnt_d = dat_cnt_q + 14'd1;
    end
    if (push) begin
      buf_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    count_d = count_q + {2'b00, push} - {2'b00, pop};

    // Clearing loses to a coincident set
    cfg_err_d      = (cfg_err_q & ~CLR_FLAGS) | set_cfg;
    timeout_flag_d = (timeout_flag_q & ~CLR_FLAGS) | set_to;
  end

  // State registers with asynchronous clear
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= S_IDLE;
      burst_q        <= 14'd0;
      req_cnt_q      <= 14'd0;
      dat_cnt_q      <= 14'd0;
      empty_cnt_q    <= '0;
      timed_out_q    <= 1'b0;
      re_pipe_q      <= '0;
      buf_q          <= '{default: 33'd0};
      wr_ptr_q       <= 2'd0;
      rd_ptr_q       <= 2'd0;
      count_q        <= 3'd0;
      frame_cnt_q    <= 10'd0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      burst_q        <= burst_d;
      req_cnt_q      <= req_cnt_d;
      dat_cnt_q      <= dat_cnt_d;
      empty_cnt_q    <= empty_cnt_d;
      timed_out_q    <= timed_out_d;
      re_pipe_q      <= re_pipe_d;
      buf_q          <= buf_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      frame_cnt_q    <= frame_cnt_d;
      done_q         <= done_d;
      cfg_err_q      <= cfg_err_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign FIFO_RE      = fifo_re;
  assign OUT_DATA     = buf_q[rd_ptr_q][31:0];
  assign OUT_VALID    = (count_q != 3'd0);
  assign OUT_LAST     = out_last;
  assign BUSY         = (state_q != S_IDLE);
  assign DONE         = done_q;
  assign CFG_ERR      = cfg_err_q;
  assign TIMEOUT_FLAG = timeout_flag_q;

endmodule

// File: tb/tb_fifo_readout_ctrl.sv
// tb/tb_fifo_readout_ctrl.sv - randomized frame-level bench for fifo_readout_ctrl at read latency 1 and 2
module tb_fifo_readout_ctrl;
  localparam logic [31:0] PAD_W = 32'hDEADBEEF;
  localparam int          TO    = 16;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        start;
  logic        clr_flags;
  logic        out_ready;
  logic [13:0] burst_len;

  logic        fifo_empty   [2];
  logic [31:0] fifo_q       [2];
  logic        fifo_re      [2];
  logic [31:0] out_data     [2];
  logic        out_valid    [2];
  logic        out_last     [2];
  logic        busy         [2];
  logic        done         [2];
  logic        cfg_err      [2];
  logic        timeout_flag [2];

  always #5 CLK = ~CLK;

  fifo_readout_ctrl #(.RD_LATENCY(1), .TIMEOUT_CYC(TO)) u_dut_l1 (
    .CLK(CLK), .RESET_N(rst_n), .START(start), .BURST_LEN(burst_len), .CLR_FLAGS(clr_flags),
    .FIFO_EMPTY(fifo_empty[0]), .FIFO_Q(fifo_q[0]), .FIFO_RE(fifo_re[0]),
    .OUT_DATA(out_data[0]), .OUT_VALID(out_valid[0]), .OUT_READY(out_ready), .OUT_LAST(out_last[0]),
    .BUSY(busy[0]), .DONE(done[0]), .CFG_ERR(cfg_err[0]), .TIMEOUT_FLAG(timeout_flag[0]));

  fifo_readout_ctrl #(.RD_LATENCY(2), .TIMEOUT_CYC(TO)) u_dut_l2 (
    .CLK(CLK), .RESET_N(rst_n), .START(start), .BURST_LEN(burst_len), .CLR_FLAGS(clr_flags),
    .FIFO_EMPTY(fifo_empty[1]), .FIFO_Q(fifo_q[1]), .FIFO_RE(fifo_re[1]),
    .OUT_DATA(out_data[1]), .OUT_VALID(out_valid[1]), .OUT_READY(out_ready), .OUT_LAST(out_last[1]),
    .BUSY(busy[1]), .DONE(done[1]), .CFG_ERR(cfg_err[1]), .TIMEOUT_FLAG(timeout_flag[1]));

  int n_checks = 0;
  int n_errors = 0;

  // Upstream FIFO: shared contents, one read pointer per DUT
  logic [31:0] fmem [0:16383];
  int          fwr = 0;
  int          frd [2];
  int          mrd = 0;
  int          data_seq = 0;
  logic [31:0] dq0 [2];
  logic [31:0] dq1 [2];
  logic        re_s [2];
  int          ready_mode = 0;

  // Expected output stream (header + data words per frame), one consumer index per DUT
  logic [32:0] exp_mem [0:4095];
  int          ewr = 0;
  int          erd [2];
  int          done_cnt [2];
  logic        hold [2];
  logic [32:0] hold_w [2];
  int          fc = 0;

  assign fifo_empty[0] = (frd[0] == fwr);
  assign fifo_empty[1] = (frd[1] == fwr);
  assign fifo_q[0]     = dq0[0];
  assign fifo_q[1]     = dq1[1];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // FIFO read data path and downstream ready, driven just after each rising edge
  always @(posedge CLK) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        frd[k] = fwr;
        dq0[k] = 32'hF000_0000;
        dq1[k] = 32'hF000_0000;
      end else begin
        dq1[k] = dq0[k];
        if (re_s[k]) begin
          dq0[k] = fmem[frd[k] % 16384];
          frd[k] = frd[k] + 1;
        end else begin
          dq0[k] = 32'hF000_0000 | ($urandom & 32'h0FFF_FFFF);
        end
      end
    end
    out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom % 2) : 1'b0;
  end

  // Output monitor on the falling edge: scoreboard, stability while stalled, DONE count
  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      re_s[k] = fifo_re[k];
      if (!rst_n) begin
        hold[k] = 1'b0;
      end else begin
        if (fifo_re[k]) check("re_while_empty", fifo_empty[k], 0);
        if (hold[k]) begin
          check("hold_valid", out_valid[k], 1);
          check("hold_word", {out_last[k], out_data[k]}, hold_w[k]);
        end
        if (out_valid[k] && out_ready) begin
          check("extra_word", erd[k] < ewr, 1);
          if (erd[k] < ewr) begin
            check(k == 0 ? "word_l1" : "word_l2", {out_last[k], out_data[k]}, exp_mem[erd[k] % 4096]);
            erd[k] = erd[k] + 1;
          end
        end
        hold[k]   = out_valid[k] && !out_ready;
        hold_w[k] = {out_last[k], out_data[k]};
        if (done[k]) done_cnt[k] = done_cnt[k] + 1;
      end
    end
  end

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fmem[fwr % 16384] = data_seq;
      fwr      = fwr + 1;
      data_seq = data_seq + 1;
    end
  endtask

  // One frame: preload n words, predict the stream from the FIFO contents, run it to completion
  task automatic run_frame(input int b, input int n, input int mode);
    int          avail;
    int          take;
    int          cyc;
    int          tgt [2];
    logic        exp_to;
    logic [9:0]  fcv;
    logic [13:0] bv;
    push_words(n);
    ready_mode = mode;
    avail = fwr - mrd;
    take  = (avail < b) ? avail : b;
    fcv   = fc[9:0];
    bv    = b[13:0];
    exp_mem[ewr % 4096] = {1'b0, 8'hA5, fcv, bv};
    ewr = ewr + 1;
    for (int i = 0; i < b; i++) begin
      exp_mem[ewr % 4096] = {(i == b - 1), (i < take) ? fmem[(mrd + i) % 16384] : PAD_W};
      ewr = ewr + 1;
    end
    mrd    = mrd + take;
    exp_to = (take < b);
    tgt[0] = done_cnt[0] + 1;
    tgt[1] = done_cnt[1] + 1;
    @(posedge CLK); #1;
    start     = 1'b1;
    burst_len = bv;
    @(posedge CLK); #1;
    start     = 1'b0;
    burst_len = 14'($urandom);
    @(posedge CLK); #1;
    check("busy_l1", busy[0], 1);
    check("busy_l2", busy[1], 1);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    cyc = 0;
    while ((done_cnt[0] < tgt[0] || done_cnt[1] < tgt[1]) && cyc < 4000) begin
      @(posedge CLK);
      cyc++;
    end
    repeat (3) @(posedge CLK);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("done_count", done_cnt[k], tgt[k]);
      check("stream_consumed", erd[k], ewr);
      check("idle_after", busy[k], 0);
      check("timeout_flag", timeout_flag[k], exp_to);
    end
    fc = (fc + 1) % 1024;
    if (exp_to) begin
      clr_flags = 1'b1;
      @(posedge CLK); #1;
      clr_flags = 1'b0;
      check("timeout_clr_l1", timeout_flag[0], 0);
      check("timeout_clr_l2", timeout_flag[1], 0);
    end
  endtask

  task automatic bad_start(input logic [13:0] b, input logic clr);
    @(posedge CLK); #1;
    start     = 1'b1;
    burst_len = b;
    clr_flags = clr;
    @(posedge CLK); #1;
    start     = 1'b0;
    clr_flags = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("cfg_err_set", cfg_err[k], 1);
      check("cfg_busy", busy[k], 0);
    end
  endtask

  task automatic clear_flags();
    @(posedge CLK); #1;
    clr_flags = 1'b1;
    @(posedge CLK); #1;
    clr_flags = 1'b0;
    for (int k = 0; k < 2; k++) check("cfg_err_clr", cfg_err[k], 0);
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      check("rst_fifo_re", fifo_re[k], 0);
      check("rst_out_valid", out_valid[k], 0);
      check("rst_out_last", out_last[k], 0);
      check("rst_out_data", out_data[k], 0);
      check("rst_busy", busy[k], 0);
      check("rst_done", done[k], 0);
      check("rst_cfg_err", cfg_err[k], 0);
      check("rst_timeout", timeout_flag[k], 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      frd[k] = 0; erd[k] = 0; done_cnt[k] = 0; hold[k] = 1'b0; re_s[k] = 1'b0;
      dq0[k] = 32'hF000_0000; dq1[k] = 32'hF000_0000;
    end
    rst_n = 1'b0; start = 1'b0; clr_flags = 1'b0; burst_len = 14'd0; out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // Preloaded 0..15, full frame with ready held high, then with random backpressure
    run_frame(16, 16, 0);
    run_frame(16, 16, 1);

    // Out-of-range lengths and flag clearing, including set-beats-clear
    bad_start(14'd0, 1'b0);
    clear_flags();
    bad_start(14'd9000, 1'b0);
    bad_start(14'd8193, 1'b1);
    clear_flags();

    // Starved frames padded out after the timeout
    run_frame(8, 3, 0);
    run_frame(8, 3, 1);
    run_frame(4, 0, 1);

    // Random lengths, fill levels and backpressure
    for (int f = 0; f < 30; f++) begin
      int b;
      int n;
      b = $urandom_range(1, 40);
      n = ($urandom % 10 < 7) ? b + $urandom_range(0, 3) : $urandom_range(0, b - 1);
      run_frame(b, n, 1 + ($urandom % 2 == 0 ? 0 : -1));
    end

    // Reset in the middle of READ abandons the frame and restarts the frame counter
    push_words(16);
    ready_mode = 2;
    @(posedge CLK); #1;
    start = 1'b1; burst_len = 14'd16;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge CLK);
    #2;
    mrd = fwr;
    fc  = 0;
    rst_n = 1'b1;
    run_frame(5, 5, 1);

    // Enough short frames to wrap the header frame counter
    for (int f = 0; f < 1025; f++) run_frame(1, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_readout_ctrl.md
FIFO_READOUT_CTRL -- requirements
Module: fifo_readout_ctrl

Interface
REQ-001 Parameter RD_LATENCY, default 1, cycles from FIFO_RE high to valid FIFO_Q (legal 1..2).
REQ-002 Parameter TIMEOUT_CYC, default 1024, consecutive FIFO_EMPTY cycles in READ before a frame is padded out.
REQ-003 Parameter PAD_WORD, default 32'hDEADBEEF, word emitted in place of missing data.
REQ-004 CLK  in  1  single clock; FIFO read clock and downstream clock.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 START  in  1  one-cycle request to read one frame; honoured only in IDLE.
REQ-007 BURST_LEN  in  14  data words per frame, legal 1..8192; sampled on an honoured START.
REQ-008 CLR_FLAGS  in  1  clears the sticky flags.
REQ-009 FIFO_EMPTY  in  1  EMPTY from the 32x8192 FIFO.
REQ-010 FIFO_Q  in  32  Q from the FIFO.
REQ-011 FIFO_RE  out  1  active-high read enable to the FIFO.
REQ-012 OUT_DATA  out  32  stream data.
REQ-013 OUT_VALID / OUT_READY  out/in  1/1  stream handshake; a transfer occurs when both are high on a CLK edge.
REQ-014 OUT_LAST  out  1  high with the final word of a frame.
REQ-015 BUSY  out  1  high in every state except IDLE.
REQ-016 DONE  out  1  one-cycle pulse after the OUT_LAST transfer.
REQ-017 CFG_ERR / TIMEOUT_FLAG  out  1/1  sticky error flags.

Function
REQ-018 States are IDLE, HEADER, READ, PAD and FLUSH.
REQ-019 IDLE->HEADER on START when 1<=BURST_LEN<=8192; an out-of-range START sets CFG_ERR and stays in IDLE.
REQ-020 HEADER pushes one word {8'hA5, FRAME_CNT[9:0], BURST_LEN[13:0]} into the output buffer when it has space, then goes to READ.
REQ-021 FRAME_CNT increments by one on each DONE and wraps 1023->0.
REQ-022 The output buffer holds 4 entries of {LAST, DATA[31:0]} in FIFO order; OUT_VALID is high whenever it is non-empty.
REQ-023 In READ, FIFO_RE is high only when FIFO_EMPTY=0, requested<BURST_LEN, and (buffer occupancy + reads in flight)<4.
REQ-024 FIFO_Q is captured RD_LATENCY cycles after each FIFO_RE cycle, exactly once per read; no captured word is ever dropped or duplicated.
REQ-025 The word for read number BURST_LEN carries LAST=1; after it is requested, the state goes to FLUSH.
REQ-026 The empty counter increments on each READ cycle with FIFO_EMPTY=1 and clears on any cycle with FIFO_EMPTY=0.
REQ-027 If the empty counter reaches TIMEOUT_CYC: set TIMEOUT_FLAG, stop FIFO_RE, wait for in-flight reads to land, then go to PAD.
REQ-028 PAD pushes PAD_WORD until the frame totals BURST_LEN data words, with LAST on the final one, then goes to FLUSH.
REQ-029 FLUSH waits until the buffer is empty and OUT_LAST has transferred, pulses DONE for one cycle and returns to IDLE.
REQ-030 START outside IDLE is ignored; BURST_LEN changes after sampling have no effect.
REQ-031 OUT_DATA, OUT_VALID and OUT_LAST hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-032 A buffer push and a pop in the same cycle are both performed; occupancy is unchanged.
REQ-033 CLR_FLAGS clears both flags; if it coincides with a setting event, the set wins.
REQ-034 The downstream sees every frame as exactly 1 header word plus BURST_LEN data words.

Reset
REQ-035 When RESET_N=0: state IDLE; FIFO_RE, OUT_VALID, OUT_LAST, BUSY, DONE, CFG_ERR and TIMEOUT_FLAG are 0; OUT_DATA is 0; FRAME_CNT, all counters and the buffer are cleared.
REQ-036 A reset in mid-frame abandons the frame; any FIFO data already read is lost, and the next frame starts with FRAME_CNT=0.

Verification
REQ-037 FIFO preloaded with 0..15, BURST_LEN=16, OUT_READY=1 -> header 0xA500_0010, then words 0..15, LAST on 15, one DONE pulse, FRAME_CNT=1.
REQ-038 Same frame with OUT_READY toggled randomly, for RD_LATENCY=1 and RD_LATENCY=2 -> identical word sequence, no loss or duplicates, buffer never exceeds 4 entries.
REQ-039 START with BURST_LEN=0, then with 9000 -> CFG_ERR=1, BUSY stays 0; CLR_FLAGS -> CFG_ERR=0.
REQ-040 BURST_LEN=8, only 3 words in the FIFO, TIMEOUT_CYC=16 -> after 16 empty cycles TIMEOUT_FLAG=1; output is header, 3 data words, 5 x 0xDEADBEEF, LAST on the last.
REQ-041 1025 back-to-back frames -> the header counter wraps from 1023 to 0.
REQ-042 RESET_N asserted mid-READ -> all outputs go to their reset values immediately; the next START produces a header with FRAME_CNT=0.
